// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM data-port arbiter: OBI request/response bundles and the master-count ceiling.
package sram_arb_pkg;

  localparam int NUM_REQ_MAX = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } obi_rsp_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set bit of req_i scanning from ptr_i upward with wrap; purely combinational.
// Zero latency, no state, no backpressure; outputs are all-zero when nothing requests.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     win_oh_o,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             win_vld_o
);

  int               w_pos;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    win_oh_o  = '0;
    win_idx_o = '0;
    win_vld_o = 1'b0;
    w_pos     = 0;
    w_idx     = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = int'(ptr_i) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      w_idx = IDX_W'(w_pos);
      if (!win_vld_o && req_i[w_idx]) begin
        win_vld_o        = 1'b1;
        win_oh_o[w_idx]  = 1'b1;
        win_idx_o        = w_idx;
      end
    end
  end

endmodule

// File: rtl/sram_d_arbiter.sv
// Round-robin share of the SRAM data OBI port among NUM_REQ masters; response 1 cycle after transfer, routed to owner.
// Backpressure: s_gnt_i low stalls every master (no gnt, pointer held). SRAM_ARB_PERF_EN adds grant/conflict counters.
module sram_d_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int CNT_W   = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       m_req_i,
  output logic [NUM_REQ-1:0]       m_gnt_o,
  input  logic [NUM_REQ*32-1:0]    m_addr_i,
  input  logic [NUM_REQ-1:0]       m_we_i,
  input  logic [NUM_REQ*4-1:0]     m_be_i,
  input  logic [NUM_REQ*32-1:0]    m_wdata_i,
  output logic [NUM_REQ-1:0]       m_rvalid_o,
  output logic [NUM_REQ*32-1:0]    m_rdata_o,
  output logic [NUM_REQ-1:0]       m_err_o,
  output logic                     s_req_o,
  input  logic                     s_gnt_i,
  output logic [31:0]              s_addr_o,
  output logic                     s_we_o,
  output logic [3:0]               s_be_o,
  output logic [31:0]              s_wdata_o,
  input  logic                     s_rvalid_i,
  input  logic [31:0]              s_rdata_i,
  input  logic                     s_illegal_i,
  output logic [NUM_REQ*CNT_W-1:0] perf_grant_o,
  output logic [CNT_W-1:0]         perf_conflict_o
);

  obi_req_t         w_mreq [NUM_REQ];
  obi_req_t         w_sel;
  obi_rsp_t         w_rsp;
  logic [NUM_REQ-1:0] w_win_oh;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_win_vld;
  logic             w_xfer;
  logic [IDX_W-1:0] w_rr_nxt;

  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] r_owner;
  logic             r_owner_vld;
  logic             r_err;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign w_mreq[k] = '{addr:  m_addr_i[k*32 +: 32],
                         we:    m_we_i[k],
                         be:    m_be_i[k*4 +: 4],
                         wdata: m_wdata_i[k*32 +: 32]};
  end

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i     (m_req_i),
    .ptr_i     (r_rr),
    .win_oh_o  (w_win_oh),
    .win_idx_o (w_win_idx),
    .win_vld_o (w_win_vld)
  );

  // One-hot select keeps the slave fields at zero when nobody requests.
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win_oh[k]) w_sel = w_mreq[k];
    end
  end

  assign s_req_o   = w_win_vld;
  assign s_addr_o  = w_sel.addr;
  assign s_we_o    = w_sel.we;
  assign s_be_o    = w_sel.be;
  assign s_wdata_o = w_sel.wdata;
  assign m_gnt_o   = w_win_oh & {NUM_REQ{s_gnt_i}};

  assign w_xfer   = s_req_o & s_gnt_i;
  assign w_rr_nxt = (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr        <= '0;
      r_owner     <= '0;
      r_owner_vld <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_xfer) begin
      r_rr        <= w_rr_nxt;
      r_owner     <= w_win_idx;
      r_owner_vld <= 1'b1;
      r_err       <= s_illegal_i;
    end else begin
      r_owner_vld <= 1'b0;
    end
  end

  assign w_rsp = '{rvalid: s_rvalid_i & r_owner_vld, rdata: s_rdata_i, err: r_err};

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_rsp
    assign m_rvalid_o[k]         = w_rsp.rvalid & (r_owner == IDX_W'(k));
    assign m_err_o[k]            = m_rvalid_o[k] & w_rsp.err;
    assign m_rdata_o[k*32 +: 32] = w_rsp.rdata;
  end

`ifdef SRAM_ARB_PERF_EN
  logic             w_conflict;
  logic [CNT_W-1:0] r_perf_conflict;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign w_conflict = |(m_req_i & (m_req_i - NUM_REQ'(1)));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_conflict <= '0;
    end else if (w_conflict && (r_perf_conflict != '1)) begin
      r_perf_conflict <= r_perf_conflict + CNT_W'(1);
    end
  end
  assign perf_conflict_o = r_perf_conflict;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_perf_grant
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_cnt <= '0;
      end else if (w_xfer && w_win_oh[k] && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
    assign perf_grant_o[k*CNT_W +: CNT_W] = r_cnt;
  end
`else
  assign perf_grant_o    = '0;
  assign perf_conflict_o = '0;
`endif

endmodule

// File: tb/tb_sram_d_arbiter.sv
// Randomized bench for sram_d_arbiter: SRAM wrapper stand-in plus a reference model of arbitration, ownership and perf counts.
module tb_sram_d_arbiter;

  localparam int N     = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [N-1:0]       m_req_i;
  logic [N-1:0]       m_gnt_o;
  logic [N*32-1:0]    m_addr_i;
  logic [N-1:0]       m_we_i;
  logic [N*4-1:0]     m_be_i;
  logic [N*32-1:0]    m_wdata_i;
  logic [N-1:0]       m_rvalid_o;
  logic [N*32-1:0]    m_rdata_o;
  logic [N-1:0]       m_err_o;
  logic               s_req_o;
  logic               s_gnt_i;
  logic [31:0]        s_addr_o;
  logic               s_we_o;
  logic [3:0]         s_be_o;
  logic [31:0]        s_wdata_o;
  logic               s_rvalid_i;
  logic [31:0]        s_rdata_i;
  logic               s_illegal_i;
  logic [N*CNT_W-1:0] perf_grant_o;
  logic [CNT_W-1:0]   perf_conflict_o;

  sram_d_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o),
    .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
    .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i),
    .s_rdata_i(s_rdata_i), .s_illegal_i(s_illegal_i),
    .perf_grant_o(perf_grant_o), .perf_conflict_o(perf_conflict_o)
  );

  always #5 clk_i = ~clk_i;

  // Wrapper flags anything outside the 0x8000_xxxx window as illegal.
  assign s_illegal_i = s_req_o & (s_addr_o[31:16] != 16'h8000);

  int n_checks = 0;
  int n_fail   = 0;

  int          exp_rr;
  bit          pend_vld;
  int          pend_owner;
  bit          pend_err;
  logic [31:0] pend_rdata;
  int          g_cnt [N];
  int          conf_cnt;
  logic [31:0] mem [logic [31:0]];

  logic [N-1:0] obs_gnt, obs_rv, obs_err;
  logic [31:0]  obs_rdata0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the requester at the smallest forward distance from the pointer.
  function automatic int pick(input logic [N-1:0] req, input int rr);
    int best  = -1;
    int bestd = N;
    for (int k = 0; k < N; k++) begin
      if (req[k] && (((k - rr + N) % N) < bestd)) begin
        best  = k;
        bestd = (k - rr + N) % N;
      end
    end
    return best;
  endfunction

  task automatic clear_model();
    exp_rr   = 0;
    pend_vld = 0;
    pend_err = 0;
    conf_cnt = 0;
    for (int k = 0; k < N; k++) g_cnt[k] = 0;
  endtask

  task automatic set_m(input int k, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wd);
    m_addr_i[k*32 +: 32]  = addr;
    m_we_i[k]             = we;
    m_be_i[k*4 +: 4]      = be;
    m_wdata_i[k*32 +: 32] = wd;
  endtask

  task automatic tick();
    int              w, nreq;
    logic [N-1:0]    eg, erv, eer;
    logic [31:0]     ea, ewd, old, nxt_rdata;
    logic            ewe, nxt_rv;
    logic [3:0]      ebe;
    logic [N*CNT_W-1:0] epg;
    logic [CNT_W-1:0]   epc;
    @(negedge clk_i);
    w = pick(m_req_i, exp_rr);
    nreq = $countones(m_req_i);
    eg = '0; ea = '0; ewe = 1'b0; ebe = '0; ewd = '0;
    if (w >= 0) begin
      ea  = m_addr_i[w*32 +: 32];
      ewe = m_we_i[w];
      ebe = m_be_i[w*4 +: 4];
      ewd = m_wdata_i[w*32 +: 32];
      if (s_gnt_i) eg[w] = 1'b1;
    end
    erv = '0;
    if (s_rvalid_i && pend_vld) erv[pend_owner] = 1'b1;
    eer = pend_err ? erv : '0;
    epg = '0; epc = '0;
`ifdef SRAM_ARB_PERF_EN
    for (int k = 0; k < N; k++) epg[k*CNT_W +: CNT_W] = CNT_W'(g_cnt[k]);
    epc = CNT_W'(conf_cnt);
`endif
    check_val("s_req", s_req_o, w >= 0);
    check_val("m_gnt", m_gnt_o, eg);
    check_val("s_addr", s_addr_o, ea);
    check_val("s_we", s_we_o, ewe);
    check_val("s_be", s_be_o, ebe);
    check_val("s_wdata", s_wdata_o, ewd);
    check_val("m_rvalid", m_rvalid_o, erv);
    check_val("m_err", m_err_o, eer);
    if (erv != '0) check_val("m_rdata", m_rdata_o[pend_owner*32 +: 32], pend_rdata);
    check_val("perf_grant", perf_grant_o, epg);
    check_val("perf_conflict", perf_conflict_o, epc);
    obs_gnt = m_gnt_o; obs_rv = m_rvalid_o; obs_err = m_err_o; obs_rdata0 = m_rdata_o[31:0];

    nxt_rv = 1'b0;
    nxt_rdata = $urandom;
    if (!rst_ni) begin
      clear_model();
    end else begin
      if (nreq >= 2 && conf_cnt < CMAX) conf_cnt++;
      if (w >= 0 && s_gnt_i) begin
        exp_rr     = (w + 1) % N;
        pend_vld   = 1;
        pend_owner = w;
        pend_err   = (ea[31:16] != 16'h8000);
        if (g_cnt[w] < CMAX) g_cnt[w]++;
        nxt_rv    = 1'b1;
        nxt_rdata = '0;
        if (!pend_err && ewe) begin
          old = mem.exists(ea) ? mem[ea] : '0;
          for (int b = 0; b < 4; b++) if (ebe[b]) old[b*8 +: 8] = ewd[b*8 +: 8];
          mem[ea] = old;
        end else if (!pend_err) begin
          nxt_rdata = mem.exists(ea) ? mem[ea] : '0;
        end
        pend_rdata = nxt_rdata;
      end else begin
        pend_vld = 0;
      end
    end
    @(posedge clk_i);
    #1;
    s_rvalid_i = nxt_rv;
    s_rdata_i  = nxt_rdata;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 32'h0000_0100;
    return 32'h8000_0000 | (32'($urandom_range(0, 7)) << 2);
  endfunction

  initial begin
    rst_ni = 1'b0; m_req_i = '0; m_addr_i = '0; m_we_i = '0; m_be_i = '0; m_wdata_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
    clear_model();

    // Reset with no requesters: everything quiet.
    repeat (3) begin
      tick();
      check_val("rst_quiet", {obs_gnt, obs_rv, obs_err}, '0);
    end
    rst_ni = 1'b1;

    // Both masters hammering with the SRAM always ready: strict alternation from M0.
    m_req_i = 2'b11; s_gnt_i = 1'b1;
    set_m(0, 32'h8000_0000, 1'b0, 4'hF, '0);
    set_m(1, 32'h8000_0004, 1'b0, 4'hF, '0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("alt_gnt", obs_gnt, (i % 2 == 0) ? 64'd1 : 64'd2);
      if (i > 0) check_val("alt_rvalid", obs_rv, (i % 2 == 0) ? 64'd2 : 64'd1);
    end
`ifdef SRAM_ARB_PERF_EN
    check_val("perf_g0_5", perf_grant_o[0 +: CNT_W], 64'd5);
    check_val("perf_g1_5", perf_grant_o[CNT_W +: CNT_W], 64'd5);
    check_val("perf_conf_10", perf_conflict_o, 64'd10);
`endif

    // M1 writes, M0 reads the same word back.
    m_req_i = 2'b10;
    set_m(1, 32'h8000_0010, 1'b1, 4'hF, 32'hDEAD_BEEF);
    tick();
    m_req_i = 2'b01;
    set_m(0, 32'h8000_0010, 1'b0, 4'hF, '0);
    tick();
    check_val("wr_rvalid_m1", obs_rv, 64'd2);
    m_req_i = 2'b00;
    tick();
    check_val("rd_rvalid_m0", obs_rv, 64'd1);
    check_val("rd_data_m0", obs_rdata0, 64'hDEAD_BEEF);

    // Illegal address: error only on M0, alongside its rvalid.
    m_req_i = 2'b01;
    set_m(0, 32'h0000_0100, 1'b0, 4'hF, '0);
    tick();
    m_req_i = 2'b00;
    tick();
    check_val("illegal_rvalid", obs_rv, 64'd1);
    check_val("illegal_err", obs_err, 64'd1);

    // Reset between transfer and response drops the response.
    m_req_i = 2'b10;
    set_m(1, 32'h8000_0008, 1'b0, 4'hF, '0);
    tick();
    m_req_i = 2'b00;
    rst_ni = 1'b0;
    clear_model();
    tick();
    check_val("rst_drop_rv", obs_rv, 64'd0);
    rst_ni = 1'b1;
    tick();
    check_val("post_rst_rv", obs_rv, 64'd0);
    m_req_i = 2'b11;
    set_m(0, 32'h8000_0000, 1'b0, 4'hF, '0);
    tick();
    check_val("post_rst_gnt", obs_gnt, 64'd1);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      m_req_i = N'($urandom);
      s_gnt_i = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < N; k++)
        set_m(k, rand_addr(), 1'($urandom), 4'($urandom), $urandom);
      tick();
    end
`ifdef SRAM_ARB_PERF_EN
    check_val("perf_conf_sat", perf_conflict_o, 64'(CMAX));
`else
    check_val("perf_tied_off", {perf_grant_o, perf_conflict_o}, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
